// File: rtl/obuft_share_arb.sv
// Round-robin arbiter sharing one OBUFT pad among NREQ requesters, with forced high-Z turnaround.
// Optional drive-time limit per grant: define OBUF_ARB_TIMEOUT_EN.
module obuft_share_arb #(
    parameter int NREQ     = 4,
    parameter int DW       = 1,
    parameter int TURN     = 2,
    parameter int MAX_HOLD = 16
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic [NREQ-1:0]           REQ,
    input  logic [NREQ*DW-1:0]        DATA,
    output logic [NREQ-1:0]           GNT,
    output logic [$clog2(NREQ)-1:0]   OWNER,
    output logic [DW-1:0]             O,
    output logic                      T
);

    localparam int OW = $clog2(NREQ);
    localparam int TW = $clog2(TURN + 1);

    if (NREQ < 2 || NREQ > 16 || DW < 1 || TURN < 1 || MAX_HOLD < 1) begin : g_bad_param
        $error("obuft_share_arb: illegal parameter value");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_TURN
    } state_t;

    state_t            state_q, state_d;
    logic [OW-1:0]     ptr_q, ptr_d;
    logic [TW-1:0]     turn_q, turn_d;
    logic [NREQ-1:0]   gnt_d;
    logic [OW-1:0]     owner_d;
    logic [DW-1:0]     o_d;
    logic              t_d;

    logic [OW:0]       idx;
    logic [OW-1:0]     win;
    logic              found;
    logic              rel;
    logic              arb;
    logic [DW-1:0]     owner_data;

`ifdef OBUF_ARB_TIMEOUT_EN
    localparam int HW = $clog2(MAX_HOLD + 1);
    logic [HW-1:0]     hold_q, hold_d;
`endif

    // Rotating priority: first request at or after the pointer wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, ptr_q} + (OW+1)'(k);
            if (idx >= (OW+1)'(NREQ)) begin
                idx = idx - (OW+1)'(NREQ);
            end
            if (!found && REQ[idx[OW-1:0]]) begin
                found = 1'b1;
                win   = idx[OW-1:0];
            end
        end
    end

    always_comb begin
        owner_data = DATA[int'(OWNER)*DW +: DW];
        rel        = !REQ[OWNER];
`ifdef OBUF_ARB_TIMEOUT_EN
        if (hold_q == HW'(MAX_HOLD)) begin
            rel = 1'b1;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        turn_d  = turn_q;
        gnt_d   = GNT;
        owner_d = OWNER;
        o_d     = O;
        t_d     = T;
        arb     = 1'b0;
`ifdef OBUF_ARB_TIMEOUT_EN
        hold_d  = hold_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                arb = 1'b1;
            end
            S_DRIVE: begin
                if (rel) begin
                    state_d = S_TURN;
                    gnt_d   = '0;
                    t_d     = 1'b1;
                    o_d     = '0;
                    turn_d  = TW'(1);
                    ptr_d   = (OWNER == OW'(NREQ - 1)) ? '0 : OWNER + OW'(1);
                end else begin
                    o_d = owner_data;
`ifdef OBUF_ARB_TIMEOUT_EN
                    hold_d = hold_q + HW'(1);
`endif
                end
            end
            S_TURN: begin
                if (turn_q == TW'(TURN)) begin
                    arb = 1'b1;
                end else begin
                    turn_d = turn_q + TW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (arb) begin
            if (found) begin
                state_d    = S_DRIVE;
                gnt_d      = '0;
                gnt_d[win] = 1'b1;
                owner_d    = win;
                t_d        = 1'b0;
                o_d        = '0;
`ifdef OBUF_ARB_TIMEOUT_EN
                hold_d     = HW'(1);
`endif
            end else begin
                state_d = S_IDLE;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            turn_q  <= '0;
            GNT     <= '0;
            OWNER   <= '0;
            O       <= '0;
            T       <= 1'b1;
`ifdef OBUF_ARB_TIMEOUT_EN
            hold_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            turn_q  <= turn_d;
            GNT     <= gnt_d;
            OWNER   <= owner_d;
            O       <= o_d;
            T       <= t_d;
`ifdef OBUF_ARB_TIMEOUT_EN
            hold_q  <= hold_d;
`endif
        end
    end

endmodule

// File: tb/tb_obuft_share_arb.sv
// Bench for obuft_share_arb: directed scenarios plus random traffic against a cycle model.
// Works with or without OBUF_ARB_TIMEOUT_EN defined.
module tb_obuft_share_arb;

    localparam int NREQ     = 4;
    localparam int DW       = 2;
    localparam int TURN     = 2;
    localparam int MAX_HOLD = 4;
`ifdef OBUF_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic                 CLK;
    logic                 RST_N;
    logic [NREQ-1:0]      REQ;
    logic [NREQ*DW-1:0]   DATA;
    logic [NREQ-1:0]      GNT;
    logic [1:0]           OWNER;
    logic [DW-1:0]        O;
    logic                 T;

    obuft_share_arb #(
        .NREQ(NREQ), .DW(DW), .TURN(TURN), .MAX_HOLD(MAX_HOLD)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .DATA(DATA),
        .GNT(GNT), .OWNER(OWNER), .O(O), .T(T)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Model: who owns the pad, how many high-Z cycles remain, rotation start.
    bit           m_busy = 0;
    int           m_owner = 0;
    int           m_gap = 0;
    int           m_ptr = 0;
    int           m_hold = 0;
    logic [DW-1:0] e_o = '0;
    int           grant_log[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic model_step();
        int w;
        if (!RST_N) begin
            m_busy = 0; m_gap = 0; m_ptr = 0; m_hold = 0; m_owner = 0; e_o = '0;
        end else if (m_busy) begin
            if (!REQ[m_owner] || (TO_EN && m_hold >= MAX_HOLD)) begin
                m_busy = 0;
                m_gap  = TURN;
                m_ptr  = (m_owner + 1) % NREQ;
                e_o    = '0;
            end else begin
                e_o = DATA[m_owner*DW +: DW];
                m_hold++;
            end
        end else if (m_gap > 1) begin
            m_gap--;
        end else begin
            m_gap = 0;
            w = rr_pick(REQ, m_ptr);
            if (w >= 0) begin
                m_busy = 1; m_owner = w; m_hold = 1; e_o = '0;
                grant_log.push_back(w);
            end
        end
    endtask

    task automatic cyc();
        logic [NREQ-1:0] eg;
        logic            rst_at_edge;
        @(posedge CLK);
        rst_at_edge = RST_N;
        model_step();
        eg = m_busy ? NREQ'(1 << m_owner) : '0;
        @(negedge CLK);
        chk("gnt", 32'(GNT), 32'(eg));
        chk("t", 32'(T), 32'(!m_busy));
        chk("o", 32'(O), 32'(e_o));
        if (m_busy) chk("owner", 32'(OWNER), 32'(m_owner));
        if (!rst_at_edge) chk("owner_rst", 32'(OWNER), 32'd0);
    endtask

    initial begin
        int exp_rr[5];
        RST_N = 1'b0;
        REQ   = '0;
        DATA  = '0;

        // Reset held with all requests active, then first grant to 0.
        REQ = 4'b1111;
        repeat (3) cyc();
        RST_N = 1'b1;
        cyc();
        chk("rst_first_gnt", 32'(GNT), 32'h1);

        // Single owner with data, then release and turnaround.
        REQ = '0;
        repeat (4) cyc();
        REQ  = 4'b0010;
        DATA = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("s2_gnt", 32'(GNT), 32'h2);
            chk("s2_o", 32'(O), (i == 0) ? 32'h0 : 32'h3);
        end
        REQ = '0;
        cyc();
        chk("s2_z1", 32'(T), 32'h1);
        cyc();
        chk("s2_z2", 32'(T), 32'h1);
        cyc();

        // Round-robin with owners dropping after 3 cycles.
        RST_N = 1'b0;
        REQ = '0;
        cyc();
        RST_N = 1'b1;
        grant_log.delete();
        REQ = 4'b1111;
        for (int i = 0; i < 30; i++) begin
            cyc();
            REQ = 4'b1111;
            if (m_busy && m_hold == 3) REQ[m_owner] = 1'b0;
        end
        exp_rr = '{0, 1, 2, 3, 0};
        chk("rr_count", 32'(grant_log.size() >= 5), 32'h1);
        for (int i = 0; i < 5 && i < grant_log.size(); i++) begin
            chk("rr_order", 32'(grant_log[i]), 32'(exp_rr[i]));
        end

        // Owner 0 drops while requester 2 raises.
        RST_N = 1'b0;
        REQ = '0;
        cyc();
        RST_N = 1'b1;
        REQ = 4'b0001;
        repeat (3) cyc();
        REQ = 4'b0100;
        cyc();
        chk("s4_t1", 32'(T), 32'h1);
        chk("s4_g1", 32'(GNT), 32'h0);
        cyc();
        chk("s4_t2", 32'(T), 32'h1);
        cyc();
        chk("s4_gnt", 32'(GNT), 32'h4);
        chk("s4_t", 32'(T), 32'h0);

        // Two requesters held forever.
        RST_N = 1'b0;
        REQ = '0;
        cyc();
        RST_N = 1'b1;
        REQ = 4'b0011;
        for (int n = 0; n < 24; n++) begin
            int ph;
            logic [3:0] pg;
            cyc();
            ph = n % 12;
            if (!TO_EN) pg = 4'b0001;
            else if (ph < 4) pg = 4'b0001;
            else if (ph < 6) pg = 4'b0000;
            else if (ph < 10) pg = 4'b0010;
            else pg = 4'b0000;
            chk("s5_pattern", 32'(GNT), 32'(pg));
        end

        // Reset during the second drive cycle clears the pointer.
        RST_N = 1'b0;
        REQ = '0;
        cyc();
        RST_N = 1'b1;
        REQ = 4'b0100;
        repeat (2) cyc();
        REQ = '0;
        repeat (2) cyc();
        REQ = 4'b0010;
        cyc();
        cyc();
        RST_N = 1'b0;
        cyc();
        chk("s6_t", 32'(T), 32'h1);
        chk("s6_gnt", 32'(GNT), 32'h0);
        RST_N = 1'b1;
        REQ = 4'b1111;
        cyc();
        chk("s6_ptr", 32'(GNT), 32'h1);

        // Random traffic.
        REQ = '0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) == 0) REQ = NREQ'($urandom);
            DATA  = (NREQ*DW)'($urandom);
            RST_N = ($urandom_range(0, 99) != 0);
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
